// File: rtl/fetch_mem_pkg.sv
// Shared definitions for the fetch/memory unit: FSM and access-kind encodings,
// reset PC and the word-alignment helper used when latching addresses.
package fetch_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'b00,
      KIND_LOAD  = 2'b01,
      KIND_STORE = 2'b10
   } kind_e;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_mem_unit_flopenr.sv
// Enabled register with asynchronous active-low reset; used for PC, Instr and Data.
module flopenr #(
   parameter int unsigned            WIDTH     = 32,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o <= RESET_VAL;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/fetch_mem_unit.sv
// Multicycle fetch/load/store sequencer: latches one memory request per access,
// holds it until mem_ready, and stalls the controller FSM meanwhile.
module fetch_mem_unit
   import fetch_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        IRWrite,
   input  logic        AdrSrc,
   input  logic        MemWrite,
   input  logic [31:0] Result,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] PC,
   output logic [31:0] Instr,
   output logic [31:0] Data,
   output logic        stall
);

   state_e      state_q;
   kind_e       kind_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic access_req;
   logic complete;

   assign access_req = IRWrite | AdrSrc;
   assign complete   = (state_q == BUSY) && mem_ready;
   assign stall      = ((state_q == IDLE) && access_req) || (state_q == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         kind_q      <= KIND_FETCH;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (access_req) begin
                  state_q     <= BUSY;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= AdrSrc & MemWrite;
                  mem_addr_q  <= word_align(AdrSrc ? ALUOut : PC);
                  mem_wdata_q <= WriteData;
                  kind_q      <= !AdrSrc ? KIND_FETCH : (MemWrite ? KIND_STORE : KIND_LOAD);
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  state_q   <= DONE;
                  mem_req_q <= 1'b0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // PC only advances while the controller is not frozen.
   flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (PCWrite & ~stall),
      .d_i    (Result),
      .q_o    (PC)
   );

   flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_instr (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (complete && (kind_q == KIND_FETCH)),
      .d_i    (mem_rdata),
      .q_o    (Instr)
   );

   flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_data (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (complete && (kind_q == KIND_LOAD)),
      .d_i    (mem_rdata),
      .q_o    (Data)
   );

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Scoreboard bench for fetch_mem_unit: expected memory requests are queued when an
// access is driven and popped when the memory handshake completes.
module tb_fetch_mem_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        PCWrite = 1'b0, IRWrite = 1'b0, AdrSrc = 1'b0, MemWrite = 1'b0;
   logic [31:0] Result = '0, ALUOut = '0, WriteData = '0, mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, stall;
   logic [31:0] mem_addr, mem_wdata, PC, Instr, Data;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] pc_model = '0, instr_model = '0, data_model = '0;

   always #5 clk = ~clk;

   fetch_mem_unit dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .Result(Result), .ALUOut(ALUOut),
      .WriteData(WriteData), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .PC(PC), .Instr(Instr), .Data(Data), .stall(stall)
   );

   always @(negedge clk) begin
      if (reset === 1'b1 && mem_req === 1'b1 && mem_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: request addr=%h we=%b with empty scoreboard", mem_addr, mem_we);
         end else begin
            mon_e = sb.pop_front();
            if (mem_addr !== mon_e.addr || mem_we !== mon_e.we || mem_wdata !== mon_e.wdata) begin
               errors++;
               $display("FAIL sb_request: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                        mem_addr, mem_we, mem_wdata, mon_e.addr, mon_e.we, mon_e.wdata);
            end
         end
      end
   end

   // Starts from IDLE at posedge+1 and returns at posedge+1 back in IDLE.
   task automatic do_access(input logic adrsrc, input logic memwrite, input logic [31:0] aluout,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                            input bit hold_req, input string name);
      exp_t e;
      int   req_cnt, stall_cnt;
      e.addr  = (adrsrc ? aluout : pc_model) & 32'hFFFF_FFFC;
      e.we    = adrsrc & memwrite;
      e.wdata = wdata;
      sb.push_back(e);
      IRWrite = !adrsrc; AdrSrc = adrsrc; MemWrite = memwrite;
      ALUOut = aluout; WriteData = wdata; mem_ready = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_req: stall=%b mem_req=%b, expected stall=1 mem_req=0", name, stall, mem_req);
      end
      stall_cnt = (stall === 1'b1) ? 1 : 0;
      req_cnt   = 0;
      @(posedge clk); #1;
      if (!hold_req) begin
         IRWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0;
      end
      for (int i = 0; i <= waits; i++) begin
         mem_ready = (i == waits);
         mem_rdata = (i == waits) ? rdata : 32'hDEAD_BEEF;
         #1;
         if (mem_req === 1'b1) req_cnt++;
         if (stall === 1'b1) stall_cnt++;
         checks++;
         if (mem_addr !== e.addr || mem_we !== e.we || Instr !== instr_model ||
             Data !== data_model || PC !== pc_model) begin
            errors++;
            $display("FAIL %s busy%0d: addr=%h we=%b Instr=%h Data=%h PC=%h, expected addr=%h we=%b Instr=%h Data=%h PC=%h",
                     name, i, mem_addr, mem_we, Instr, Data, PC, e.addr, e.we, instr_model, data_model, pc_model);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      if (!adrsrc) instr_model = rdata;
      else if (!memwrite) data_model = rdata;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || Instr !== instr_model || Data !== data_model || PC !== pc_model) begin
         errors++;
         $display("FAIL %s done: mem_req=%b stall=%b Instr=%h Data=%h PC=%h, expected 0 0 %h %h %h",
                  name, mem_req, stall, Instr, Data, PC, instr_model, data_model, pc_model);
      end
      checks++;
      if (req_cnt != waits + 1 || stall_cnt != waits + 2) begin
         errors++;
         $display("FAIL %s cycles: mem_req_cycles=%0d stall_cycles=%0d, expected %0d %0d",
                  name, req_cnt, stall_cnt, waits + 1, waits + 2);
      end
      if (PCWrite) pc_model = Result;
      @(posedge clk); #1;
      checks++;
      if (PC !== pc_model || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after: PC=%h mem_req=%b, expected PC=%h mem_req=0", name, PC, mem_req, pc_model);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (PC !== 32'h0 || Instr !== 32'h0 || Data !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: PC=%h Instr=%h Data=%h req=%b we=%b addr=%h wdata=%h stall=%b, expected all 0",
                  PC, Instr, Data, mem_req, mem_we, mem_addr, mem_wdata, stall);
      end
      #21;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fetch();
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE04F_000F, 0, 1'b0, "fetch");
   endtask

   task automatic test_wait_states();
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE3A0_1005, 3, 1'b0, "wait_states");
   endtask

   task automatic test_store_load();
      do_access(1'b1, 1'b1, 32'h60, 32'h7, 32'hCAFE_F00D, 0, 1'b0, "store");
      do_access(1'b1, 1'b0, 32'h60, 32'h0, 32'h7, 1, 1'b0, "load");
      checks++;
      if (Data !== 32'h7 || Instr !== 32'hE3A0_1005) begin
         errors++;
         $display("FAIL store_load_regs: Data=%h Instr=%h, expected 00000007 e3a01005", Data, Instr);
      end
   endtask

   task automatic test_misaligned();
      do_access(1'b1, 1'b0, 32'h63, 32'h0, 32'h1234_5678, 0, 1'b0, "misaligned");
   endtask

   task automatic test_pc_gating();
      PCWrite = 1'b1; Result = 32'h4;
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE59F_1010, 0, 1'b0, "pc_gating");
      PCWrite = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE281_1001, 0, 1'b1, "b2b_first");
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE351_000A, 2, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid_access();
      IRWrite = 1'b1; AdrSrc = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      IRWrite = 1'b0;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_busy: mem_req=%b, expected 1", mem_req);
      end
      #2;
      reset = 1'b0;
      #1;
      pc_model = '0; instr_model = '0; data_model = '0;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall !== 1'b0 || PC !== 32'h0 ||
          Instr !== 32'h0 || Data !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_async: req=%b addr=%h stall=%b PC=%h Instr=%h Data=%h, expected all 0",
                  mem_req, mem_addr, stall, PC, Instr, Data);
      end
      mem_ready = 1'b1; mem_rdata = 32'hBAD0_0BAD;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req !== 1'b0 || Instr !== 32'h0 || Data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ready_ignored%0d: req=%b Instr=%h Data=%h, expected 0 0 0",
                     i, mem_req, Instr, Data);
         end
      end
      mem_ready = 1'b0;
      do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'hE1A0_0000, 0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_wait_states();
      test_store_load();
      test_misaligned();
      test_pc_gating();
      test_back_to_back();
      test_reset_mid_access();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d requests never completed, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
